// File: rtl/wb_cmd_pkg.sv
// Opcodes, response codes and FSM states shared by the host command driver and wishbone_master.
// A command/response word is a 2-bit code on top of a 32-bit payload.
package wb_cmd_pkg;

  localparam int WORD_W = 34;

  typedef enum logic [1:0] {
    CMD_RD   = 2'b00,
    CMD_WR   = 2'b01,
    CMD_ADDR = 2'b10,
    CMD_RST  = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    RSP_WACK  = 2'b00,
    RSP_RDATA = 2'b01,
    RSP_AACK  = 2'b10,
    RSP_ERR   = 2'b11
  } rsp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_ADDR,
    ST_WAIT_ADDR,
    ST_SEND_OP,
    ST_WAIT_OP,
    ST_ABORT,
    ST_DONE
  } drv_state_t;

  function automatic logic [WORD_W-1:0] mk_cmd(input cmd_op_t op, input logic [31:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/wb_cmd_timeout.sv
// Response watchdog: counts waiting cycles, flags expiry at TIMEOUT-1.
// clear has priority over enable; expired is a decode of the registered count.
module wb_cmd_timeout #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_host_cmd_driver.sv
// Turns single-word client reads/writes into set-address + op commands for the wishbone master.
// Latency 3 cycles on an address-cache hit, 5 on a miss; req_ready only in IDLE, commands held through cmd_busy.
module wb_host_cmd_driver
  import wb_cmd_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              cmd_stb,
  output logic [WORD_W-1:0] cmd_word,
  input  logic              cmd_busy,
  input  logic              rsp_stb,
  input  logic [WORD_W-1:0] rsp_word
);

  drv_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] last_addr;
  logic              cache_vld;
  logic              in_wait;
  logic              to_expired;
  logic [1:0]        rsp_code;

  assign in_wait  = (state == ST_WAIT_ADDR) || (state == ST_WAIT_OP);
  assign rsp_code = rsp_word[WORD_W-1:32];

  wb_cmd_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait && !rsp_stb),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cmd_stb    <= 1'b0;
      cmd_word   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      last_addr  <= '0;
      cache_vld  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cmd_stb   <= 1'b1;
            if (cache_vld && (last_addr == req_addr)) begin
              state    <= ST_SEND_OP;
              cmd_word <= req_we ? mk_cmd(CMD_WR, req_wdata) : mk_cmd(CMD_RD, 32'd0);
            end else begin
              state    <= ST_SEND_ADDR;
              cmd_word <= mk_cmd(CMD_ADDR, 32'(req_addr));
            end
          end
        end
        ST_SEND_ADDR: begin
          if (!cmd_busy) begin
            cmd_stb <= 1'b0;
            state   <= ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: begin
          if (rsp_stb) begin
            if (rsp_code == RSP_AACK) begin
              last_addr <= addr_q;
              cache_vld <= 1'b1;
              cmd_stb   <= 1'b1;
              cmd_word  <= we_q ? mk_cmd(CMD_WR, wdata_q) : mk_cmd(CMD_RD, 32'd0);
              state     <= ST_SEND_OP;
            end else begin
              err_q     <= 1'b1;
              cache_vld <= 1'b0;
              state     <= ST_DONE;
            end
          end else if (to_expired) begin
            err_q     <= 1'b1;
            cache_vld <= 1'b0;
            cmd_stb   <= 1'b1;
            cmd_word  <= mk_cmd(CMD_RST, 32'd0);
            state     <= ST_ABORT;
          end
        end
        ST_SEND_OP: begin
          if (!cmd_busy) begin
            cmd_stb <= 1'b0;
            state   <= ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          // Only the ack kind matching the request direction completes cleanly.
          if (rsp_stb) begin
            state <= ST_DONE;
            if (we_q ? (rsp_code == RSP_WACK) : (rsp_code == RSP_RDATA)) begin
              if (!we_q) begin
                rdata_q <= rsp_word[31:0];
              end
            end else begin
              err_q     <= 1'b1;
              cache_vld <= 1'b0;
            end
          end else if (to_expired) begin
            err_q     <= 1'b1;
            cache_vld <= 1'b0;
            cmd_stb   <= 1'b1;
            cmd_word  <= mk_cmd(CMD_RST, 32'd0);
            state     <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          if (!cmd_busy) begin
            cmd_stb <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          resp_rdata <= rdata_q;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_host_cmd_driver.sv
// Bench for wb_host_cmd_driver: directed plan steps then randomized requests against a memory/cache model.
// An inline master stub acks on the cycle after each accepted command, with injectable busy/error/silence.
module tb_wb_host_cmd_driver;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cmd_stb;
  logic [33:0] cmd_word;
  logic        cmd_busy;
  logic        rsp_stb;
  logic [33:0] rsp_word;

  always #5 clk = ~clk;

  wb_host_cmd_driver #(
    .ADDR_W  (10),
    .TIMEOUT (TIMEOUT),
    .TO_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .cmd_stb    (cmd_stb),
    .cmd_word   (cmd_word),
    .cmd_busy   (cmd_busy),
    .rsp_stb    (rsp_stb),
    .rsp_word   (rsp_word)
  );

  int          checks = 0;
  int          errors = 0;

  // stub modes: 0 normal, 1 error on op, 2 silent, 3 wrong response kind, 4 ack address only
  int          stub_mode;
  int          busy_left;
  bit          pend;
  logic [33:0] pend_word;
  bit          stb_seen;
  logic [33:0] held_word;
  logic [9:0]  stub_addr;
  logic [31:0] stub_mem [0:1023];
  logic [33:0] words [$];

  // reference model: expected memory contents and address-cache state
  logic [31:0] m_mem [0:1023];
  bit          m_valid;
  logic [9:0]  m_addr;

  int          lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stub_cycle();
    logic respond;
    rsp_stb  = 1'b0;
    rsp_word = '0;
    if (pend) begin
      pend    = 1'b0;
      respond = (pend_word[33:32] != 2'b11) && (stub_mode != 2) &&
                !(stub_mode == 4 && pend_word[33:32] != 2'b10);
      if (respond) begin
        rsp_stb = 1'b1;
        case (pend_word[33:32])
          2'b10: begin
            stub_addr = pend_word[9:0];
            rsp_word  = (stub_mode == 3) ? {2'b01, 32'h0} : {2'b10, 32'h0};
          end
          2'b01: begin
            if (stub_mode == 1)      rsp_word = {2'b11, 32'h0};
            else if (stub_mode == 3) rsp_word = {2'b10, 32'h0};
            else begin
              stub_mem[stub_addr] = pend_word[31:0];
              rsp_word = {2'b00, 32'h0};
            end
          end
          default: begin
            if (stub_mode == 1)      rsp_word = {2'b11, 32'h0};
            else if (stub_mode == 3) rsp_word = {2'b10, 32'h0};
            else                     rsp_word = {2'b01, stub_mem[stub_addr]};
          end
        endcase
      end
    end
    cmd_busy = cmd_stb && (busy_left > 0);
    if (cmd_busy) busy_left--;
    if (cmd_stb) begin
      if (stb_seen) chk("cmd_word_stable", cmd_word, held_word);
      else begin
        stb_seen  = 1'b1;
        held_word = cmd_word;
      end
    end
    if (cmd_stb && !cmd_busy) begin
      words.push_back(cmd_word);
      pend      = 1'b1;
      pend_word = cmd_word;
      stb_seen  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_req(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                         input int busy_n, input int mode);
    bit          hit;
    logic [33:0] exp_w [$];
    logic [33:0] op_w;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          cyc;
    int          acc;
    bit          got;
    logic        got_err;
    logic [31:0] got_rd;

    hit  = m_valid && (m_addr == addr);
    op_w = we ? {2'b01, wd} : {2'b00, 32'h0};
    if (!hit) exp_w.push_back({2'b10, 22'h0, addr});
    case (mode)
      2: begin
        if (hit) exp_w.push_back(op_w);
        exp_w.push_back(34'h3_0000_0000);
        exp_lat = TIMEOUT + 3 + busy_n;
      end
      3: begin
        if (hit) exp_w.push_back(op_w);
        exp_lat = 3 + busy_n;
      end
      default: begin
        exp_w.push_back(op_w);
        exp_lat = (hit ? 3 : 5) + busy_n;
      end
    endcase
    exp_err = (mode != 0);
    exp_rd  = (mode == 0 && !we) ? m_mem[addr] : 32'h0;
    if (mode == 0) begin
      m_valid = 1'b1;
      m_addr  = addr;
      if (we) m_mem[addr] = wd;
    end else begin
      m_valid = 1'b0;
    end

    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    stub_mode = mode;
    busy_left = busy_n;
    words.delete();
    cyc = 0;
    acc = -1;
    got = 1'b0;
    got_err = 1'b0;
    got_rd = '0;
    while (!got && cyc < 200) begin
      if (req_valid && req_ready) acc = cyc + 1;
      stub_cycle();
      cyc++;
      if (acc == cyc) req_valid = 1'b0;
      if (resp_valid) begin
        got     = 1'b1;
        got_err = resp_err;
        got_rd  = resp_rdata;
      end
    end
    req_valid = 1'b0;
    chk("resp_seen", 64'(got), 64'd1);
    lat = cyc - acc;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("resp_err", 64'(got_err), 64'(exp_err));
    chk("resp_rdata", 64'(got_rd), 64'(exp_rd));
    chk("cmd_count", 64'(words.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < words.size(); k++)
      chk("cmd_word_seq", 64'(words[k]), 64'(exp_w[k]));
    stub_cycle();
    chk("resp_pulse_width", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int          sel;
    int          r;
    logic [9:0]  a;
    logic [9:0]  last_a;
    bit          drop;
    int          n;

    for (int i = 0; i < 1024; i++) begin
      stub_mem[i] = 32'hC0DE_0000 | i;
      m_mem[i]    = 32'hC0DE_0000 | i;
    end
    m_valid = 1'b0;
    m_addr = '0;
    stub_mode = 0;
    busy_left = 0;
    pend = 1'b0;
    pend_word = '0;
    stb_seen = 1'b0;
    held_word = '0;
    stub_addr = '0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    cmd_busy = 1'b0;
    rsp_stb = 1'b0;
    rsp_word = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_cmd_stb", 64'(cmd_stb), 64'd0);
    chk("rst_cmd_word", 64'(cmd_word), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", 64'(req_ready), 64'd1);

    // miss write, then cached read of the same word
    run_req(1'b1, 10'h004, 32'hDEAD_BEEF, 0, 0);
    chk("plan_wr_addr_word", 64'(words[0]), 64'h2_0000_0004);
    chk("plan_wr_data_word", 64'(words[1]), 64'h1_DEAD_BEEF);
    run_req(1'b0, 10'h004, 32'h0, 0, 0);
    chk("plan_rd_hit_latency", 64'(lat), 64'd3);

    run_req(1'b1, 10'h155, 32'h0BAD_F00D, 4, 0);
    run_req(1'b0, 10'h3FF, 32'h0, 0, 1);
    run_req(1'b0, 10'h3FF, 32'h0, 0, 0);
    chk("plan_err_resends_addr", 64'(words[0][33:32]), 64'd2);
    run_req(1'b0, 10'h0AA, 32'h0, 0, 2);
    run_req(1'b1, 10'h0AA, 32'h5555_AAAA, 0, 3);
    run_req(1'b1, 10'h0AA, 32'h5555_AAAA, 0, 0);
    run_req(1'b0, 10'h0AA, 32'h0, 0, 2);

    // reset while the op is outstanding
    req_we = 1'b1;
    req_addr = 10'h200;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    stub_mode = 4;
    busy_left = 0;
    words.delete();
    drop = 1'b0;
    n = 0;
    while (words.size() < 2 && n < 20) begin
      if (req_valid && req_ready) drop = 1'b1;
      stub_cycle();
      if (drop) req_valid = 1'b0;
      n++;
    end
    chk("mid_rst_reached_op", 64'(words.size()), 64'd2);
    stub_cycle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("mid_rst_resp_err", 64'(resp_err), 64'd0);
    chk("mid_rst_cmd_stb", 64'(cmd_stb), 64'd0);
    chk("mid_rst_cmd_word", 64'(cmd_word), 64'd0);
    pend = 1'b0;
    stb_seen = 1'b0;
    rsp_stb = 1'b0;
    cmd_busy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    m_valid = 1'b0;
    run_req(1'b0, 10'h200, 32'h0, 0, 0);

    last_a = 10'h200;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      r   = $urandom_range(0, 9);
      case (sel)
        0: a = 10'h004;
        1: a = 10'h3FF;
        2: a = last_a;
        default: a = 10'($urandom_range(0, 1023));
      endcase
      run_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
              (r < 7) ? 0 : r - 6);
      last_a = a;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
